// File: rtl/bcd_timer_counter.sv
// Multi-digit BCD up-counter with prescaler, start/stop FSM, clear and load.
// Digit increments ripple combinationally through a chain of per-digit cells.

// Single-digit BCD incrementor: 9 with carry wraps to 0 and carries out.
module bcd_digit_inc (
  input  logic [3:0] i_d,
  input  logic       i_ci,
  output logic [3:0] o_q,
  output logic       o_co
);
  // Combinational increment with carry.
  always_comb begin
    o_q  = i_d;
    o_co = 1'b0;
    if (i_ci) begin
      if (i_d == 4'd9) begin
        o_q  = 4'd0;
        o_co = 1'b1;
      end else begin
        o_q = i_d + 4'd1;
      end
    end
  end
endmodule

module bcd_timer_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 100000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_load_value,
  output logic [4*NUM_DIGITS-1:0] o_digits,
  output logic                    o_running,
  output logic                    o_tick,
  output logic                    o_overflow,
  output logic                    o_load_err
);
  localparam int DW = 4 * NUM_DIGITS;
  // At least one prescaler bit so PRESCALE=1 still elaborates.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   digits_q, digits_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick_q, tick_d;
  logic            ovf_q, ovf_d;
  logic            lerr_q, lerr_d;

  logic [DW-1:0]         inc_digits;
  logic [NUM_DIGITS:0]   carry;
  logic [DW-1:0]         load_clean;
  logic                  load_bad;
  logic                  step;

  // Digit 0 always sees carry_in=1; the chain forms the +1 ripple.
  assign carry[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit_inc u_inc (
        .i_d  (digits_q[4*g +: 4]),
        .i_ci (carry[g]),
        .o_q  (inc_digits[4*g +: 4]),
        .o_co (carry[g+1])
      );
    end
  endgenerate

  // Replace any non-BCD load nibble with 0 and flag it.
  always_comb begin
    load_clean = i_load_value;
    load_bad   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i_load_value[4*i +: 4] > 4'd9) begin
        load_clean[4*i +: 4] = 4'd0;
        load_bad             = 1'b1;
      end
    end
  end

  assign step = (state_q == ST_RUNNING) && (presc_q == PRE_MAX);

  // Next-state: written lowest priority first so later ifs override
  // (step < start/stop < load < clear).
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    ovf_d    = ovf_q;
    lerr_d   = 1'b0;

    if (state_q == ST_RUNNING) presc_d = step ? '0 : presc_q + PW'(1);

    if (step) begin
      digits_d = inc_digits;
      tick_d   = 1'b1;
      if (carry[NUM_DIGITS]) ovf_d = 1'b1;
    end

    if (i_stop) begin
      state_d = ST_STOPPED;
    end else if (i_start) begin
      state_d = ST_RUNNING;
      // Fresh start: first step lands exactly PRESCALE cycles later.
      if (state_q == ST_STOPPED) presc_d = '0;
    end

    // Step only happens while RUNNING, so it never collides with a load.
    if (i_load && (state_q == ST_STOPPED)) begin
      digits_d = load_clean;
      lerr_d   = load_bad;
    end

    if (i_clear) begin
      digits_d = '0;
      presc_d  = '0;
      ovf_d    = 1'b0;
      tick_d   = 1'b0;
      lerr_d   = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_STOPPED;
      digits_q <= '0;
      presc_q  <= '0;
      tick_q   <= 1'b0;
      ovf_q    <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      ovf_q    <= ovf_d;
      lerr_q   <= lerr_d;
    end
  end

  assign o_digits   = digits_q;
  assign o_running  = (state_q == ST_RUNNING);
  assign o_tick     = tick_q;
  assign o_overflow = ovf_q;
  assign o_load_err = lerr_q;
endmodule
